// File: rtl/viterbi_pkg.sv
// Shared types and sizing for the Viterbi decode controller and its helpers.
package viterbi_pkg;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned PW          = 3;
  localparam int unsigned MW          = 4;
  localparam int unsigned NORM_THRESH = 12;

  typedef logic [1:0]       sym_t;
  typedef logic [MW-1:0]    metric_t;
  typedef logic [PW-1:0]    ptr_t;
  typedef logic [DEPTH-1:0] byte_t;

  typedef enum logic [2:0] {IDLE, RUN, NORM, FLUSH, DRAIN} state_e;

  // One issue towards the ACS/selector
  typedef struct packed {
    sym_t sym;
    ptr_t ptr;
  } issue_t;

  // Output buffer entry
  typedef struct packed {
    byte_t data;
    logic  last;
  } dec_beat_t;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Symbol-in, ACS-issue and decoded-byte signals of the Viterbi controller.
interface viterbi_ctrl_if import viterbi_pkg::*;;

  logic    sym_valid;
  logic    sym_ready;
  sym_t    sym_in;
  logic    frame_last;
  metric_t metric_00;
  metric_t metric_01;
  metric_t metric_10;
  metric_t metric_11;
  logic    sel_refresh;
  byte_t   sel_out;
  logic    acs_valid;
  sym_t    acs_sym;
  ptr_t    write_pointer;
  logic    norm;
  metric_t norm_sub;
  logic    dec_valid;
  logic    dec_ready;
  byte_t   dec_data;
  logic    dec_last;
  logic    busy;

  modport master (
    output sym_valid, sym_in, frame_last, metric_00, metric_01, metric_10, metric_11,
           sel_refresh, sel_out, dec_ready,
    input  sym_ready, acs_valid, acs_sym, write_pointer, norm, norm_sub,
           dec_valid, dec_data, dec_last, busy
  );

  modport slave (
    input  sym_valid, sym_in, frame_last, metric_00, metric_01, metric_10, metric_11,
           sel_refresh, sel_out, dec_ready,
    output sym_ready, acs_valid, acs_sym, write_pointer, norm, norm_sub,
           dec_valid, dec_data, dec_last, busy
  );

endinterface

// File: rtl/metric_minmax.sv
// Combinational minimum and maximum of four unsigned path metrics.
module metric_minmax import viterbi_pkg::*; (
  input  metric_t m0_i,
  input  metric_t m1_i,
  input  metric_t m2_i,
  input  metric_t m3_i,
  output metric_t min_c_o,
  output metric_t max_c_o
);

  metric_t lo01, hi01, lo23, hi23;

  // Pairwise sort, then reduce each side
  always_comb begin
    lo01    = (m0_i < m1_i) ? m0_i : m1_i;
    hi01    = (m0_i < m1_i) ? m1_i : m0_i;
    lo23    = (m2_i < m3_i) ? m2_i : m3_i;
    hi23    = (m2_i < m3_i) ? m3_i : m2_i;
    min_c_o = (lo01 < lo23) ? lo01 : lo23;
    max_c_o = (hi01 > hi23) ? hi01 : hi23;
  end

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi decode sequencer: symbol issue, metric normalisation, frame flush
// and a one-entry back-pressured buffer for decoded bytes.
module viterbi_ctrl import viterbi_pkg::*; (
  input logic          clk,
  input logic          rst,
  viterbi_ctrl_if.slave bus
);

  state_e    state_q, state_d;
  ptr_t      ptr_q, ptr_d;
  ptr_t      flush_cnt_q, flush_cnt_d;
  logic      last_pend_q, last_pend_d;
  logic      overflow_q, overflow_d;
  logic      sym_ready_q, sym_ready_d;
  logic      acs_valid_q, acs_valid_d;
  issue_t    issue_q, issue_d;
  logic      norm_q, norm_d;
  metric_t   norm_sub_q, norm_sub_d;
  logic      dec_valid_q, dec_valid_d;
  dec_beat_t buf_q, buf_d;
  logic      busy_q, busy_d;

  logic      accept;
  logic      stall;
  logic      dec_take;
  metric_t   m_min, m_max;

  metric_minmax u_minmax (
    .m0_i    (bus.metric_00),
    .m1_i    (bus.metric_01),
    .m2_i    (bus.metric_10),
    .m3_i    (bus.metric_11),
    .min_c_o (m_min),
    .max_c_o (m_max)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    flush_cnt_d = flush_cnt_q;
    last_pend_d = last_pend_q;
    overflow_d  = overflow_q;
    issue_d     = issue_q;
    acs_valid_d = 1'b0;
    norm_d      = 1'b0;
    norm_sub_d  = '0;
    buf_d       = buf_q;
    dec_valid_d = dec_valid_q;
    accept      = bus.sym_valid && sym_ready_q;
    // Next issue would close a window while the previous byte is still parked
    stall       = dec_valid_q && (ptr_q == ptr_t'(DEPTH - 1));
    dec_take    = dec_valid_q && bus.dec_ready;

    if (accept) begin
      acs_valid_d = 1'b1;
      issue_d     = '{sym: bus.sym_in, ptr: ptr_q};
      ptr_d       = ptr_q + ptr_t'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = bus.frame_last ? FLUSH : RUN;
          flush_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept && bus.frame_last) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else if (m_max >= metric_t'(NORM_THRESH)) begin
          state_d    = NORM;
          norm_d     = 1'b1;
          norm_sub_d = m_min;
        end
      end
      NORM: state_d = RUN;
      FLUSH: begin
        if (!stall) begin
          acs_valid_d = 1'b1;
          issue_d     = '{sym: 2'b00, ptr: ptr_q};
          ptr_d       = ptr_q + ptr_t'(1);
          flush_cnt_d = flush_cnt_q + ptr_t'(1);
          if (flush_cnt_q == ptr_t'(DEPTH - 1)) begin
            state_d     = DRAIN;
            last_pend_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dec_take && buf_q.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new selector byte always wins over a concurrent downstream accept
    if (bus.sel_refresh) begin
      if (dec_valid_q && !bus.dec_ready) overflow_d = 1'b1;
      buf_d       = '{data: bus.sel_out, last: last_pend_q};
      dec_valid_d = 1'b1;
      last_pend_d = 1'b0;
    end else if (dec_take) begin
      dec_valid_d = 1'b0;
      buf_d.last  = 1'b0;
    end

    sym_ready_d = ((state_d == IDLE) || (state_d == RUN)) &&
                  !(dec_valid_d && (ptr_d == ptr_t'(DEPTH - 1)));
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      flush_cnt_q <= '0;
      last_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      sym_ready_q <= 1'b0;
      acs_valid_q <= 1'b0;
      issue_q     <= '0;
      norm_q      <= 1'b0;
      norm_sub_q  <= '0;
      dec_valid_q <= 1'b0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      flush_cnt_q <= flush_cnt_d;
      last_pend_q <= last_pend_d;
      overflow_q  <= overflow_d;
      sym_ready_q <= sym_ready_d;
      acs_valid_q <= acs_valid_d;
      issue_q     <= issue_d;
      norm_q      <= norm_d;
      norm_sub_q  <= norm_sub_d;
      dec_valid_q <= dec_valid_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
    end
  end

  // Sticky overflow is a debug-only flag with no port
  logic unused_overflow;
  assign unused_overflow = overflow_q;

  assign bus.sym_ready     = sym_ready_q;
  assign bus.acs_valid     = acs_valid_q;
  assign bus.acs_sym       = issue_q.sym;
  assign bus.write_pointer = issue_q.ptr;
  assign bus.norm          = norm_q;
  assign bus.norm_sub      = norm_sub_q;
  assign bus.dec_valid     = dec_valid_q;
  assign bus.dec_data      = buf_q.data;
  assign bus.dec_last      = buf_q.last;
  assign bus.busy          = busy_q;

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Sequencing controller for the Viterbi decode datapath (ACS + survivor `selector`). It accepts received code-symbol pairs over a valid/ready handshake and issues them to the ACS/selector with `valid_in` and a wrapping 3-bit `write_pointer`. It triggers path-metric normalisation before the 4-bit metrics overflow, flushes each frame with tail symbols, and buffers each decoded byte from the selector into a back-pressured output stream.

## Interface
- `DEPTH`, 8: traceback window in symbols; equals the selector path width.
- `PW`, 3: write-pointer width, log2(DEPTH).
- `MW`, 4: path-metric width.
- `NORM_THRESH`, 12: normalisation threshold on the largest metric.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sym_valid`  in  1  input symbol pair available.
- `sym_ready`  out  1  controller accepts a symbol this cycle.
- `sym_in`  in  2  received coded bit pair.
- `frame_last`  in  1  qualifies `sym_in` as the last symbol of the frame.
- `metric_00`, `metric_01`, `metric_10`, `metric_11`  in  MW each  current ACS path metrics.
- `sel_refresh`  in  1  selector pulse: `sel_out` holds a decoded byte.
- `sel_out`  in  DEPTH  decoded byte from the selector.
- `acs_valid`  out  1  drives `valid_in` of the ACS/selector.
- `acs_sym`  out  2  symbol issued with `acs_valid`.
- `write_pointer`  out  PW  slot index issued with `acs_valid`.
- `norm`  out  1  one-cycle pulse: ACS subtracts `norm_sub` from all metrics.
- `norm_sub`  out  MW  minimum metric, valid while `norm` is high.
- `dec_valid`  out  1  decoded byte available.
- `dec_ready`  in  1  downstream accepts the decoded byte.
- `dec_data`  out  DEPTH  decoded byte.
- `dec_last`  out  1  marks the final byte of the frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered. On reset every output is 0, state is IDLE and the pointer is 0. `sym_ready` rises at the first edge after `rst` falls.
- States:
  - IDLE: a symbol accepted goes to RUN.
  - RUN: a symbol accepted with `frame_last` goes to FLUSH. Largest metric ≥ NORM_THRESH goes to NORM.
  - NORM: lasts one cycle, then returns to RUN.
  - FLUSH: after DEPTH tail symbols, goes to DRAIN.
  - DRAIN: when the final byte is accepted downstream, goes to IDLE.
- Issue: each accepted symbol produces exactly one `acs_valid` cycle carrying `acs_sym` and the current pointer. The pointer then increments, wrapping 7→0.
- NORM: `norm`=1, `norm_sub`=min(metric_00..11). There is no issue and `sym_ready`=0. Metric compare uses unsigned MW-bit values.
- FLUSH: issues DEPTH symbols of `00` on consecutive cycles, ignoring `sym_valid` (`sym_ready`=0). Normalisation is suppressed during FLUSH.
- Output buffer: one byte plus a last flag, loaded on `sel_refresh`.
  - `dec_valid` stays high until `dec_valid && dec_ready`.
  - The `sel_refresh` that follows the final flush issue sets `dec_last`=1 with that byte.
- Stall: no issue (FLUSH included) while the buffer is full and pointer = DEPTH-1 (the next issue would complete a window and produce a new refresh). `sym_ready`=0 for that duration.
- If `sel_refresh` arrives while the buffer is full, the byte is overwritten and sticky `overflow` is set. This is an internal debug register, not a port. The stall rule makes this unreachable in a correct system.
- Simultaneous buffer load and downstream accept: the load wins and `dec_valid` stays 1.

## Timing
- Handshake at edge N → `acs_valid`, `acs_sym`, `write_pointer` valid in cycle N+1. Peak throughput is one symbol per cycle.
- Normalisation check samples metrics every RUN cycle. NORM is entered at the sampling edge, and `sym_ready` drops at that same edge.
- `sel_refresh` at edge N → `dec_valid`=1 in cycle N+1.
- `rst` mid-frame: immediate return to IDLE. The output buffer and pointer are cleared and no `dec_last` is produced.

## Structure
- Shared `viterbi_pkg` holds: state enum (IDLE, RUN, NORM, FLUSH, DRAIN), DEPTH, PW, MW, NORM_THRESH, and the symbol type.
- Sub-module `metric_minmax`: combinational min and max of four MW-bit metrics. It is reusable by the ACS.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0. Release → `sym_ready`=1 one edge later, `busy`=0.
- Streaming: 8 back-to-back symbols with the lowest metric = 0 → `acs_valid` high 8 consecutive cycles with `write_pointer` 0..7, then the next issue uses 0.
- Normalisation: metrics {13,9,10,11} in RUN → one cycle of `norm`=1, `norm_sub`=9, `sym_ready`=0, no `acs_valid`.
- Back-pressure: `dec_ready`=0 with one byte buffered and pointer = 7 → `sym_ready` held 0. Raise `dec_ready` → byte accepted, issue of slot 7 resumes next cycle.
- Frame end: symbol with `frame_last`=1 → 8 issues of `acs_sym`=00, then the next refresh byte appears with `dec_last`=1. After it is accepted, `busy`=0.
- Reset mid-FLUSH (after 3 tail issues) → IDLE, pointer 0, `dec_valid`=0, no `dec_last`.
